// File: rtl/board_io_pkg.sv
// Shared definitions for board I/O conditioning: debounce state encoding,
// the default stability window and a small state decoding helper.
package board_io_pkg;

  // Debounce FSM states; the encoding is shared with other board I/O logic.
  typedef enum logic [1:0] {
    DB_LOW       = 2'd0,
    DB_WAIT_HIGH = 2'd1,
    DB_HIGH      = 2'd2,
    DB_WAIT_LOW  = 2'd3
  } db_state_t;

  // 10 ms of stability at the 50 MHz board clock.
  localparam int DB_CYCLES_DEFAULT = 500000;

  // Debounced level implied by a state: high while settled high or while
  // a falling change is still being qualified.
  function automatic logic db_level(input db_state_t s);
    logic lvl;
    case (s)
      DB_HIGH:     lvl = 1'b1;
      DB_WAIT_LOW: lvl = 1'b1;
      DB_LOW:      lvl = 1'b0;
      default:     lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchronizer, four-state qualification
// FSM with a stability counter, and registered level/edge-strobe outputs.
module debounce_chan
  import board_io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  // Count value on which the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // FSM, counter and output registers; outputs follow the next state so
  // the strobe lines up with the first cycle of the new level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DB_LOW;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      db    <= db_level(state_nxt);
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Next-state and strobe decode; a wait state restarts from its settled
  // state as soon as the synced input disagrees.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      DB_LOW: begin
        if (s2) begin
          state_nxt = DB_WAIT_HIGH;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      DB_WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = DB_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_HIGH;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DB_HIGH: begin
        if (!s2) begin
          state_nxt = DB_WAIT_LOW;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      DB_WAIT_LOW: begin
        if (s2) begin
          state_nxt = DB_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_LOW;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DB_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/input_debounce.sv
// Debounces WIDTH independent switch/button inputs; each channel is a
// self-contained debounce_chan and the top only gathers their outputs.
module input_debounce
  import board_io_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_in[i]),
      .db    (db_out[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i])
    );
  end

endmodule
